pim_input_buffer: RTL
=====================

Name: pim_input_buffer

Overview:
- Assembles 32-bit CPU/peripheral-bus writes into 1024-bit input vectors for the PIM macro.
- Holds two 1024-bit lines in ping-pong fashion: software fills one line while the PIM array consumes the other.
- The PIM side takes each line through a valid/ready handshake.
- Byte ordering is the exact inverse of the PIM output-buffer readback path, so a vector round-trips unchanged.

Parameters:
- WORD_W, 32, bus word width; fixed, not overridable.
- LINE_W, 1024, PIM vector width; LINE_W/WORD_W = 32 words per line.
- NUM_LINES, 2, line slots; design and verification only at 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: asynchronous, active-low.
- input_i  in  32  write data word.
- input_write_en_i  in  1  write strobe; one word per cycle.
- clear_i  in  1  synchronous clear of pointers, flags and overflow.
- line_o  out  1024  line presented to the PIM array.
- line_valid_o  out  1  line_o holds a complete line.
- line_ready_i  in  1  PIM array accepts line_o this cycle.
- full_o  out  1  both lines full; further writes are dropped.
- count_o  out  2  number of full lines, 0..2.
- overflow_o  out  1  sticky: a write was dropped.

Behaviour:
- Reset (async): all storage, wr_line, wr_idx[4:0], rd_line, both line states and overflow_o go to 0. All outputs are 0.
- Per-line state: EMPTY, FILLING or FULL.
  - EMPTY -> FILLING on the first accepted write.
  - FILLING -> FULL on the write with wr_idx == 31.
  - FULL -> EMPTY on handshake pop.
- Write acceptance: a write is accepted when input_write_en_i = 1 and line[wr_line] != FULL.
  - Word k = wr_idx is stored with byte j (input_i[8j+7:8j]) at line bits [1023-8*(4k+j) -: 8]. Word 0 byte 0 is therefore line bits [1023:1016].
  - wr_idx increments and wraps 31 -> 0; on that wrap, wr_line toggles.
- Dropped write: a write to a FULL line is dropped. Storage and pointers are unchanged and overflow_o is set to 1 the next cycle.
- Read side:
  - line_valid_o = (line[rd_line] == FULL).
  - line_o = storage of rd_line when valid, else 0 (combinational).
  - Pop when line_valid_o && line_ready_i: line[rd_line] -> EMPTY and rd_line toggles.
- Latency: the write of word 31 makes line_valid_o = 1 in the following cycle. No combinational path from input_i to line_o.
- Status outputs:
  - count_o = number of FULL lines, registered-state derived.
  - full_o = (count_o == 2).
- Simultaneous write-complete and pop on different lines: both take effect and count_o is unchanged.
- A write to line A while line A is being popped cannot occur, because a popped line is FULL and FULL lines reject writes.
- Backpressure: line_ready_i = 0 holds line_o and line_valid_o stable indefinitely.
- clear_i has priority over writes and pops.
  - Pointers, states and overflow_o are zeroed; storage is untouched.
  - line_valid_o is 0 in the next cycle.
- Reset mid-fill: the partial line is discarded with all state.

Optional Feature:
- Macro: PIM_IN_PARTIAL_FLUSH_EN.
- Defined:
  - Adds port flush_i, in, 1.
  - When flush_i = 1 and line[wr_line] == FILLING, any same-cycle write is applied first.
  - Words with index >= the post-write wr_idx are zeroed, the line goes to FULL, wr_idx -> 0 and wr_line toggles.
  - Flush with the line EMPTY or FULL has no effect.
  - clear_i overrides flush_i.
- Undefined: no flush_i port; a line completes only after 32 writes.

Test Plan:
- Reset, then 32 writes of word k = 32'h0302_0100 + k*32'h0404_0404 -> line_valid_o = 1 on the cycle after the 32nd write; line_o[1023:1016] = 8'h00; line_o[7:0] = 8'h7F; count_o = 1.
- 64 writes with line_ready_i = 0 -> full_o = 1, count_o = 2. A 65th write sets overflow_o = 1 and leaves line_o unchanged. Ready pulse -> first line popped, second line presented, count_o = 1.
- Word 31 of line 1 written in the same cycle as line 0 is popped -> count_o stays 1; rd_line = 1; line 1 data is presented next cycle.
- 10 writes, then clear_i -> count_o = 0, line_valid_o = 0, overflow_o = 0. The next 32 writes land in line 0 starting at word 0.
- Async rst_ni asserted mid-fill (wr_idx = 17) -> all outputs 0 immediately; post-reset fill behaves as in test 1.
- With PIM_IN_PARTIAL_FLUSH_EN: 5 writes of 32'hFFFF_FFFF, then flush_i -> line_valid_o = 1; line_o[1023:864] all ones; line_o[863:0] = 0.

Source files
------------

// File: rtl/pim_input_buffer.sv
// Ping-pong input buffer: packs 32-bit bus writes into 1024-bit PIM vectors.
// Optional partial-line flush is built when PIM_IN_PARTIAL_FLUSH_EN is defined.
module pim_input_buffer (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [31:0]         input_i,
   input  logic                input_write_en_i,
   input  logic                clear_i,
`ifdef PIM_IN_PARTIAL_FLUSH_EN
   input  logic                flush_i,
`endif
   output logic [1023:0]       line_o,
   output logic                line_valid_o,
   input  logic                line_ready_i,
   output logic                full_o,
   output logic [1:0]          count_o,
   output logic                overflow_o
);

   localparam int WORD_W    = 32;
   localparam int LINE_W    = 1024;
   localparam int NUM_LINES = 2;
   localparam int WORDS     = LINE_W / WORD_W;

   typedef enum logic [1:0] {EMPTY, FILLING, FULL} line_state_e;

   line_state_e       state_q [NUM_LINES];
   line_state_e       state_d [NUM_LINES];
   logic              wr_line_q, wr_line_d;
   logic              rd_line_q, rd_line_d;
   logic              overflow_q, overflow_d;
   logic [4:0]        wr_idx_q, wr_idx_d;
   logic [WORD_W-1:0] mem_q [NUM_LINES][WORDS];

   logic              write_ok;
   logic              pop;
   logic              line_valid;
   logic              flush_fire;

   // Byte 0 of a bus word lands at the most significant byte of its slot.
   function automatic logic [WORD_W-1:0] to_line_order(input logic [WORD_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign write_ok   = input_write_en_i && (state_q[wr_line_q] != FULL);
   assign line_valid = (state_q[rd_line_q] == FULL);
   assign pop        = line_valid && line_ready_i;

`ifdef PIM_IN_PARTIAL_FLUSH_EN
   logic [4:0] flush_idx;
   // A write completing the line already closes it, so flush has nothing to add.
   assign flush_fire = flush_i && (state_q[wr_line_q] == FILLING) &&
                       !(write_ok && (wr_idx_q == 5'd31));
   assign flush_idx  = wr_idx_q + {4'd0, write_ok};
`else
   assign flush_fire = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      wr_idx_d   = wr_idx_q;
      wr_line_d  = wr_line_q;
      rd_line_d  = rd_line_q;
      overflow_d = overflow_q;
      if (clear_i) begin
         for (int l = 0; l < NUM_LINES; l++) state_d[l] = EMPTY;
         wr_idx_d   = '0;
         wr_line_d  = 1'b0;
         rd_line_d  = 1'b0;
         overflow_d = 1'b0;
      end else begin
         if (write_ok) begin
            wr_idx_d = wr_idx_q + 5'd1;
            if (wr_idx_q == 5'd31) begin
               state_d[wr_line_q] = FULL;
               wr_line_d          = ~wr_line_q;
            end else begin
               state_d[wr_line_q] = FILLING;
            end
         end else if (input_write_en_i) begin
            overflow_d = 1'b1;
         end
         if (flush_fire) begin
            state_d[wr_line_q] = FULL;
            wr_idx_d           = '0;
            wr_line_d          = ~wr_line_q;
         end
         // The popped line is FULL, so it never collides with the write line.
         if (pop) begin
            state_d[rd_line_q] = EMPTY;
            rd_line_d          = ~rd_line_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int l = 0; l < NUM_LINES; l++) state_q[l] <= EMPTY;
         wr_idx_q   <= '0;
         wr_line_q  <= 1'b0;
         rd_line_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         for (int l = 0; l < NUM_LINES; l++) state_q[l] <= state_d[l];
         wr_idx_q   <= wr_idx_d;
         wr_line_q  <= wr_line_d;
         rd_line_q  <= rd_line_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int l = 0; l < NUM_LINES; l++)
            for (int k = 0; k < WORDS; k++) mem_q[l][k] <= '0;
      end else if (!clear_i) begin
         if (write_ok) mem_q[wr_line_q][wr_idx_q] <= to_line_order(input_i);
`ifdef PIM_IN_PARTIAL_FLUSH_EN
         if (flush_fire)
            for (int k = 0; k < WORDS; k++)
               if (5'(k) >= flush_idx) mem_q[wr_line_q][k] <= '0;
`endif
      end
   end

   always_comb begin
      line_o = '0;
      if (line_valid)
         for (int k = 0; k < WORDS; k++)
            line_o[LINE_W-1-WORD_W*k -: WORD_W] = mem_q[rd_line_q][k];
   end

   assign line_valid_o = line_valid;
   assign count_o      = {1'b0, state_q[0] == FULL} + {1'b0, state_q[1] == FULL};
   assign full_o       = (count_o == 2'd2);
   assign overflow_o   = overflow_q;

endmodule
